dat_write: RTL

// SD data-line transmitter; the host-to-card counterpart of the data-line receiver.

---
 rtl/dat_write.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dat_write.sv
// SD DAT-line block transmitter: start bit, data, per-line CRC16, end bit,
// then CRC status token capture and card-busy wait on DAT0.
module dat_write #(
  parameter int MaxBlockBitSize = 10,
  parameter int StatusTimeout   = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       sd_clk_en_i,
  input  logic                       start_i,
  input  logic [MaxBlockBitSize-1:0] block_size_i,
  input  logic                       bus_width_is_4_i,
  input  logic                       data_valid_i,
  output logic                       data_ready_o,
  input  logic [31:0]                data_i,
  input  logic [3:0]                 dat_i,
  output logic [3:0]                 dat_o,
  output logic                       dat_en_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [2:0]                 crc_status_o,
  output logic                       crc_status_err_o,
  output logic                       timeout_o,
  output logic                       underrun_o
);

  localparam int CW = MaxBlockBitSize + 4;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] C3 = CW'(3);
  localparam logic [CW-1:0] C15 = CW'(15);
  localparam logic [CW-1:0] TO_LAST =
    CW'(StatusTimeout - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PREP, S_START, S_DAT, S_CRC,
    S_END, S_WAIT, S_STAT, S_BUSY, S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hold_q, word_q;
  logic hold_full_q;
  logic [3:0][15:0] crc_q;
  logic [2:0] status_q;
  logic err_q, timeout_q, underrun_q;

  logic tick, bus4, accept, load, go;
  logic set_to, cap_st, fin_st;
  logic word_end, dat_last;
  logic [CW-1:0] required;
  logic [7:0] cur_byte;
  logic [3:0] data_bits, crc_bits, start_bits;
  logic unused;

  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic        b
  );
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign tick = sd_clk_en_i;
  assign bus4 = bus_width_is_4_i;
  assign accept = data_valid_i & ~hold_full_q;
  assign data_ready_o = ~hold_full_q;
  assign busy_o = (state_q != S_IDLE);
  assign unused = ^dat_i[3:1];

  assign crc_status_o = status_q;
  assign crc_status_err_o = err_q;
  assign timeout_o = timeout_q;
  assign underrun_o = underrun_q;

  assign required = bus4 ? CW'({block_size_i, 1'b0})
                         : CW'({block_size_i, 3'b000});
  assign dat_last = (cnt_q == required - ONE);
  assign word_end = bus4 ? (cnt_q[2:0] == 3'd7)
                         : (cnt_q[4:0] == 5'd31);
  assign start_bits = bus4 ? 4'h0 : 4'hE;
  assign crc_bits = bus4 ?
    {crc_q[3][15], crc_q[2][15], crc_q[1][15], crc_q[0][15]} :
    {3'b111, crc_q[0][15]};

  // Pick the byte of the current word addressed by the bit counter
  always_comb begin
    if (bus4) cur_byte = word_q[{cnt_q[2:1], 3'b000} +: 8];
    else      cur_byte = word_q[{cnt_q[4:3], 3'b000} +: 8];
  end

  // Line values for the current data tick, MSB first
  always_comb begin
    data_bits = 4'hF;
    unique case (1'b1)
      bus4 && !cnt_q[0]: data_bits = cur_byte[7:4];
      bus4 && cnt_q[0]:  data_bits = cur_byte[3:0];
      default: data_bits = {3'b111, cur_byte[~cnt_q[2:0]]};
    endcase
  end

  // Next state, counter and line drive
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    go       = 1'b0;
    set_to   = 1'b0;
    cap_st   = 1'b0;
    fin_st   = 1'b0;
    dat_o    = 4'hF;
    dat_en_o = 1'b0;
    done_o   = 1'b0;
    unique case (state_q)
      S_IDLE: if (tick && start_i) begin
        go = 1'b1;
        cnt_d = '0;
        state_d = S_PREP;
      end
      S_PREP: begin
        dat_en_o = 1'b1;
        if (tick && hold_full_q) begin
          load = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        dat_en_o = 1'b1;
        dat_o = start_bits;
        if (tick) begin
          cnt_d = '0;
          state_d = S_DAT;
        end
      end
      S_DAT: begin
        dat_en_o = 1'b1;
        dat_o = data_bits;
        if (tick) begin
          if (dat_last) begin
            cnt_d = '0;
            state_d = S_CRC;
          end else begin
            cnt_d = cnt_q + ONE;
            load = word_end;
          end
        end
      end
      S_CRC: begin
        dat_en_o = 1'b1;
        dat_o = crc_bits;
        if (tick) begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == C15) begin
            cnt_d = '0;
            state_d = S_END;
          end
        end
      end
      S_END: begin
        dat_en_o = 1'b1;
        if (tick) begin
          cnt_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: if (tick) begin
        cnt_d = cnt_q + ONE;
        if (!dat_i[0]) begin
          cnt_d = '0;
          state_d = S_STAT;
        end else if (cnt_q == TO_LAST) begin
          set_to = 1'b1;
          state_d = S_DONE;
        end
      end
      S_STAT: if (tick) begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == C3) begin
          fin_st = 1'b1;
          cnt_d = '0;
          state_d = S_BUSY;
        end else begin
          cap_st = 1'b1;
        end
      end
      S_BUSY: if (tick && dat_i[0]) state_d = S_DONE;
      S_DONE: if (tick) begin
        done_o = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and bit counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end

  // Holding register and word register; underrun sends zeros
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
      hold_full_q <= 1'b0;
      word_q <= '0;
    end else begin
      if (load) word_q <= hold_full_q ? hold_q : '0;
      if (accept) hold_q <= data_i;
      hold_full_q <= accept | (hold_full_q & ~load);
    end
  end

  // Per-line CRC16: accumulate over data, then shift out
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= '0;
    end else if (state_q == S_IDLE) begin
      crc_q <= '0;
    end else if (tick && state_q == S_DAT) begin
      for (int i = 0; i < 4; i++)
        crc_q[i] <= crc_step(crc_q[i], data_bits[i]);
    end else if (tick && state_q == S_CRC) begin
      for (int i = 0; i < 4; i++)
        crc_q[i] <= {crc_q[i][14:0], 1'b0};
    end
  end

  // Completion flags and status token capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q <= '0;
      err_q <= 1'b0;
      timeout_q <= 1'b0;
      underrun_q <= 1'b0;
    end else if (go) begin
      status_q <= '0;
      err_q <= 1'b0;
      timeout_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (load && state_q == S_DAT && !hold_full_q)
        underrun_q <= 1'b1;
      if (set_to) timeout_q <= 1'b1;
      if (cap_st) status_q <= {status_q[1:0], dat_i[0]};
      if (fin_st) err_q <= (status_q != 3'b010);
    end
  end

endmodule
